// File: rtl/write_back_arb.sv
// Write-back arbiter: per-producer result FIFOs merged onto a single registered
// write-back port, with fixed-priority or round-robin selection and flush kill.
module write_back_arb #(
   parameter int              XLEN      = 32,
   parameter int              NCH       = 3,
   parameter int              DEPTH     = 2,
   parameter int              ARB_MODE  = 1,
   parameter logic [NCH-1:0]  KILL_MASK = {NCH{1'b1}}
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH-1:0]       in_v,
   input  logic [5*NCH-1:0]     in_rd,
   input  logic [XLEN*NCH-1:0]  in_data,
   output logic [NCH-1:0]       in_ready,
   input  logic                 flush,
   output logic [XLEN-1:0]      result,
   output logic [4:0]           rd,
   output logic                 result_v,
   output logic                 busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = $clog2(NCH);

   logic [NCH-1:0]  full;
   logic [NCH-1:0]  empty;
   logic [NCH-1:0]  kill;
   logic [NCH-1:0]  push;
   logic [NCH-1:0]  eligible;
   logic [NCH-1:0]  grant_oh;
   logic [4:0]      head_rd   [NCH];
   logic [XLEN-1:0] head_data [NCH];

   logic [PW-1:0]   grant_idx;
   logic            grant_any;
   logic [PW-1:0]   rr_ptr_reg;
   logic [PW-1:0]   rr_ptr_next;
   logic [PW:0]     rr_sum;

   logic [XLEN-1:0] result_reg;
   logic [4:0]      rd_reg;
   logic            result_v_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         logic [4:0]      mem_rd   [DEPTH];
         logic [XLEN-1:0] mem_data [DEPTH];
         logic [AW:0]     wr_ptr_reg;
         logic [AW:0]     rd_ptr_reg;

         assign kill[gi]      = flush & KILL_MASK[gi];
         assign full[gi]      = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                                (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
         assign empty[gi]     = (wr_ptr_reg == rd_ptr_reg);
         assign in_ready[gi]  = ~full[gi] & ~kill[gi];
         // rd = 0 completes the handshake but is never buffered
         assign push[gi]      = in_v[gi] & in_ready[gi] & (in_rd[5*gi +: 5] != 5'd0);
         assign head_rd[gi]   = mem_rd[rd_ptr_reg[AW-1:0]];
         assign head_data[gi] = mem_data[rd_ptr_reg[AW-1:0]];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
            end else if (kill[gi]) begin
               rd_ptr_reg <= wr_ptr_reg;
            end else begin
               if (push[gi])     wr_ptr_reg <= wr_ptr_reg + 1'b1;
               if (grant_oh[gi]) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
         end

         always_ff @(posedge clk) begin
            if (push[gi]) begin
               mem_rd[wr_ptr_reg[AW-1:0]]   <= in_rd[5*gi +: 5];
               mem_data[wr_ptr_reg[AW-1:0]] <= in_data[XLEN*gi +: XLEN];
            end
         end
      end
   endgenerate

   assign eligible = ~empty & ~kill;

   always_comb begin
      grant_oh    = '0;
      grant_idx   = '0;
      grant_any   = 1'b0;
      rr_sum      = '0;
      rr_ptr_next = rr_ptr_reg;
      if (ARB_MODE == 0) begin
         for (int i = NCH - 1; i >= 0; i--) begin
            if (eligible[i]) begin
               grant_idx = PW'(i);
               grant_any = 1'b1;
            end
         end
      end else begin
         // scan from the pointer upward, wrapping past NCH-1
         for (int k = 0; k < NCH; k++) begin
            rr_sum = {1'b0, rr_ptr_reg} + (PW+1)'(k);
            if (rr_sum >= (PW+1)'(NCH)) rr_sum = rr_sum - (PW+1)'(NCH);
            if (!grant_any && eligible[rr_sum[PW-1:0]]) begin
               grant_idx = rr_sum[PW-1:0];
               grant_any = 1'b1;
            end
         end
      end
      if (grant_any) begin
         grant_oh[grant_idx] = 1'b1;
         rr_ptr_next = (grant_idx == PW'(NCH - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_reg   <= '0;
         rd_reg       <= '0;
         result_v_reg <= 1'b0;
         rr_ptr_reg   <= '0;
      end else begin
         result_v_reg <= grant_any;
         rr_ptr_reg   <= rr_ptr_next;
         if (grant_any) begin
            result_reg <= head_data[grant_idx];
            rd_reg     <= head_rd[grant_idx];
         end
      end
   end

   assign result   = result_reg;
   assign rd       = rd_reg;
   assign result_v = result_v_reg;
   assign busy     = (|(~empty)) | result_v_reg;

endmodule

// File: tb/tb_write_back_arb.sv
// Bench for write_back_arb: three instances (round-robin, fixed priority,
// partial kill mask) share one stimulus and are compared with a queue model.
module tb_write_back_arb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  in_v = '0;
   logic [14:0] in_rd = '0;
   logic [95:0] in_data = '0;
   logic        flush = 1'b0;

   logic [2:0]  rdy_w  [3];
   logic [31:0] res_w  [3];
   logic [4:0]  rd_w   [3];
   logic        v_w    [3];
   logic        busy_w [3];

   int          n_cmp = 0;
   int          n_fail = 0;

   // model state, index 0 = rr, 1 = fixed priority, 2 = kill mask 011
   int          arb_m [3] = '{1, 0, 1};
   logic [2:0]  km_m  [3] = '{3'b111, 3'b111, 3'b011};
   logic [36:0] mq [3][3][$];
   int          rr_m [3];
   logic        ev [3];
   logic [4:0]  erd [3];
   logic [31:0] edata [3];
   logic        ebusy [3];
   logic [2:0]  rdy_exp [3];
   logic [2:0]  rdy_act [3];

   always #5 clk = ~clk;

   write_back_arb #(.XLEN(32), .NCH(3), .DEPTH(2), .ARB_MODE(1), .KILL_MASK(3'b111)) dut_rr (
      .clk(clk), .rst(rst), .in_v(in_v), .in_rd(in_rd), .in_data(in_data),
      .in_ready(rdy_w[0]), .flush(flush), .result(res_w[0]), .rd(rd_w[0]),
      .result_v(v_w[0]), .busy(busy_w[0]));

   write_back_arb #(.XLEN(32), .NCH(3), .DEPTH(2), .ARB_MODE(0), .KILL_MASK(3'b111)) dut_fp (
      .clk(clk), .rst(rst), .in_v(in_v), .in_rd(in_rd), .in_data(in_data),
      .in_ready(rdy_w[1]), .flush(flush), .result(res_w[1]), .rd(rd_w[1]),
      .result_v(v_w[1]), .busy(busy_w[1]));

   write_back_arb #(.XLEN(32), .NCH(3), .DEPTH(2), .ARB_MODE(1), .KILL_MASK(3'b011)) dut_km (
      .clk(clk), .rst(rst), .in_v(in_v), .in_rd(in_rd), .in_data(in_data),
      .in_ready(rdy_w[2]), .flush(flush), .result(res_w[2]), .rd(rd_w[2]),
      .result_v(v_w[2]), .busy(busy_w[2]));

   task automatic set_ch(input int c, input logic v, input logic [4:0] r, input logic [31:0] d);
      in_v[c] = v;
      in_rd[5*c +: 5] = r;
      in_data[32*c +: 32] = d;
   endtask

   function automatic logic [2:0] model_ready(input int m);
      logic [2:0] r;
      logic [2:0] kl;
      kl = flush ? km_m[m] : 3'b000;
      for (int c = 0; c < 3; c++) r[c] = (mq[m][c].size() < 2) && !kl[c];
      return r;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 3; m++) begin
         for (int c = 0; c < 3; c++) mq[m][c].delete();
         rr_m[m] = 0; ev[m] = 1'b0; erd[m] = '0; edata[m] = '0; ebusy[m] = 1'b0;
      end
   endtask

   // one rising edge of the abstract behaviour: pick, pop, then flush/enqueue
   task automatic model_step();
      for (int m = 0; m < 3; m++) begin
         logic [2:0]  kl;
         logic [2:0]  rdy;
         logic [36:0] e;
         int          g;
         int          c;
         kl  = flush ? km_m[m] : 3'b000;
         rdy = model_ready(m);
         g = -1;
         for (int k = 0; k < 3; k++) begin
            c = (arb_m[m] == 0) ? k : (rr_m[m] + k) % 3;
            if (g < 0 && mq[m][c].size() > 0 && !kl[c]) g = c;
         end
         if (g >= 0) begin
            e = mq[m][g].pop_front();
            ev[m] = 1'b1; erd[m] = e[36:32]; edata[m] = e[31:0];
            rr_m[m] = (g + 1) % 3;
         end else begin
            ev[m] = 1'b0;
         end
         for (int j = 0; j < 3; j++) begin
            if (kl[j]) mq[m][j].delete();
            else if (in_v[j] && rdy[j] && in_rd[5*j +: 5] != 5'd0)
               mq[m][j].push_back({in_rd[5*j +: 5], in_data[32*j +: 32]});
         end
         ebusy[m] = ev[m];
         for (int j = 0; j < 3; j++) if (mq[m][j].size() > 0) ebusy[m] = 1'b1;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      for (int m = 0; m < 3; m++) begin
         rdy_exp[m] = model_ready(m);
         rdy_act[m] = rdy_w[m];
      end
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      in_v = '0; flush = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      for (int m = 0; m < 3; m++) begin
         n_cmp++;
         if (v_w[m] !== 1'b0 || rd_w[m] !== 5'd0 || res_w[m] !== 32'd0 || busy_w[m] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out dut%0d: v=%b rd=%0d res=%h busy=%b, want 0 0 0 0", m, v_w[m], rd_w[m], res_w[m], busy_w[m]);
         end
         n_cmp++;
         if (rdy_w[m] !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_ready dut%0d: got %b want 111", m, rdy_w[m]);
         end
      end
      $display("test_reset done");
   endtask

   task automatic test_single();
      do_reset();
      set_ch(0, 1'b1, 5'd5, 32'hA5);
      tick();
      in_v = '0;
      n_cmp++;
      if (v_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL single_e1: v=%b busy=%b want v=0 busy=1", v_w[0], busy_w[0]);
      end
      tick();
      n_cmp++;
      if (v_w[0] !== 1'b1 || rd_w[0] !== 5'd5 || res_w[0] !== 32'hA5) begin
         n_fail++;
         $display("FAIL single_e2: v=%b rd=%0d res=%h want 1 5 a5", v_w[0], rd_w[0], res_w[0]);
      end
      tick();
      n_cmp++;
      if (v_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || rd_w[0] !== 5'd5) begin
         n_fail++;
         $display("FAIL single_e3: v=%b busy=%b rd=%0d want 0 0 5(held)", v_w[0], busy_w[0], rd_w[0]);
      end
      $display("test_single done");
   endtask

   task automatic test_contention();
      int exp_rr [6] = '{1, 2, 3, 1, 2, 3};
      do_reset();
      for (int c = 0; c < 3; c++) set_ch(c, 1'b1, 5'(c + 1), $urandom);
      tick();
      for (int t = 0; t < 6; t++) begin
         for (int c = 0; c < 3; c++) in_data[32*c +: 32] = $urandom;
         tick();
         n_cmp++;
         if (v_w[0] !== 1'b1 || rd_w[0] !== 5'(exp_rr[t])) begin
            n_fail++;
            $display("FAIL rr_seq[%0d]: v=%b rd=%0d want 1 %0d", t, v_w[0], rd_w[0], exp_rr[t]);
         end
         n_cmp++;
         if (v_w[1] !== 1'b1 || rd_w[1] !== 5'd1) begin
            n_fail++;
            $display("FAIL fp_seq[%0d]: v=%b rd=%0d want 1 1", t, v_w[1], rd_w[1]);
         end
      end
      $display("test_contention done");
   endtask

   task automatic test_full();
      logic [31:0] got [$];
      do_reset();
      set_ch(0, 1'b1, 5'd1, 32'h100);
      set_ch(2, 1'b1, 5'd7, 32'hD1);
      tick();
      in_data[32*2 +: 32] = 32'hD2;
      tick();
      n_cmp++;
      if (rdy_act[1][2] !== 1'b1) begin
         n_fail++;
         $display("FAIL full_ready_1: got %b want 1", rdy_act[1][2]);
      end
      if (v_w[1] && rd_w[1] == 5'd7) got.push_back(res_w[1]);
      in_data[32*2 +: 32] = 32'hD3;
      tick();
      n_cmp++;
      if (rdy_act[1][2] !== 1'b0) begin
         n_fail++;
         $display("FAIL full_ready_2: got %b want 0", rdy_act[1][2]);
      end
      if (v_w[1] && rd_w[1] == 5'd7) got.push_back(res_w[1]);
      in_v = '0;
      for (int t = 0; t < 8; t++) begin
         tick();
         if (v_w[1] && rd_w[1] == 5'd7) got.push_back(res_w[1]);
      end
      n_cmp++;
      if (got.size() != 2 || got[0] !== 32'hD1 || got[1] !== 32'hD2) begin
         n_fail++;
         $display("FAIL full_order: got %0d entries first=%h, want 2 entries d1 d2",
                  got.size(), (got.size() > 0) ? got[0] : 32'h0);
      end
      $display("test_full done");
   endtask

   task automatic test_rd_zero();
      do_reset();
      set_ch(1, 1'b1, 5'd0, 32'hDEAD);
      for (int t = 0; t < 4; t++) begin
         tick();
         n_cmp++;
         if (rdy_act[0] !== 3'b111 || v_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_zero[%0d]: ready=%b v=%b busy=%b want 111 0 0", t, rdy_act[0], v_w[0], busy_w[0]);
         end
      end
      in_v = '0;
      $display("test_rd_zero done");
   endtask

   task automatic test_flush();
      logic [31:0] ch2 [$];
      int          ch0_seen;
      ch0_seen = 0;
      do_reset();
      // one ch0 transfer moves the round-robin pointer to channel 1
      set_ch(0, 1'b1, 5'd9, 32'h99);
      tick();
      in_v = '0;
      repeat (2) tick();
      set_ch(0, 1'b1, 5'd4, 32'hA0);
      set_ch(2, 1'b1, 5'd6, 32'hB0);
      tick();
      in_data[31:0] = 32'hA1;
      in_data[95:64] = 32'hB1;
      tick();
      if (v_w[2] && rd_w[2] == 5'd6) ch2.push_back(res_w[2]);
      if (v_w[2] && rd_w[2] == 5'd4) ch0_seen++;
      in_v = '0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_cmp++;
      if (rdy_act[2] !== 3'b100) begin
         n_fail++;
         $display("FAIL flush_ready: got %b want 100", rdy_act[2]);
      end
      if (v_w[2] && rd_w[2] == 5'd6) ch2.push_back(res_w[2]);
      if (v_w[2] && rd_w[2] == 5'd4) ch0_seen++;
      for (int t = 0; t < 5; t++) begin
         tick();
         if (v_w[2] && rd_w[2] == 5'd6) ch2.push_back(res_w[2]);
         if (v_w[2] && rd_w[2] == 5'd4) ch0_seen++;
      end
      n_cmp++;
      if (ch0_seen != 0) begin
         n_fail++;
         $display("FAIL flush_kill: ch0 results seen %0d want 0", ch0_seen);
      end
      n_cmp++;
      if (ch2.size() != 2 || ch2[0] !== 32'hB0 || ch2[1] !== 32'hB1) begin
         n_fail++;
         $display("FAIL flush_keep: got %0d ch2 entries first=%h want 2 b0 b1",
                  ch2.size(), (ch2.size() > 0) ? ch2[0] : 32'h0);
      end
      n_cmp++;
      if (busy_w[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_idle: busy=%b want 0", busy_w[2]);
      end
      $display("test_flush done");
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int c = 0; c < 3; c++) set_ch(c, 1'b1, 5'(c + 10), $urandom);
      repeat (2) tick();
      in_v = '0;
      #2 rst = 1'b1;
      #1;
      for (int m = 0; m < 3; m++) begin
         n_cmp++;
         if (v_w[m] !== 1'b0 || busy_w[m] !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_drop dut%0d: v=%b busy=%b want 0 0", m, v_w[m], busy_w[m]);
         end
      end
      #2 rst = 1'b0;
      model_reset();
      #1;
      for (int m = 0; m < 3; m++) begin
         n_cmp++;
         if (rdy_w[m] !== 3'b111) begin
            n_fail++;
            $display("FAIL midrst_ready dut%0d: got %b want 111", m, rdy_w[m]);
         end
      end
      repeat (2) tick();
      n_cmp++;
      if (v_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_quiet: v=%b busy=%b want 0 0", v_w[0], busy_w[0]);
      end
      $display("test_reset_mid done");
   endtask

   task automatic test_random();
      do_reset();
      for (int t = 0; t < 400; t++) begin
         for (int c = 0; c < 3; c++)
            set_ch(c, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
         flush = ($urandom_range(0, 9) == 0);
         tick();
         for (int m = 0; m < 3; m++) begin
            n_cmp++;
            if (rdy_act[m] !== rdy_exp[m]) begin
               n_fail++;
               $display("FAIL rand_ready t%0d dut%0d: got %b want %b", t, m, rdy_act[m], rdy_exp[m]);
            end
            n_cmp++;
            if (v_w[m] !== ev[m] || rd_w[m] !== erd[m] || res_w[m] !== edata[m]) begin
               n_fail++;
               $display("FAIL rand_out t%0d dut%0d: v=%b rd=%0d res=%h want %b %0d %h",
                        t, m, v_w[m], rd_w[m], res_w[m], ev[m], erd[m], edata[m]);
            end
            n_cmp++;
            if (busy_w[m] !== ebusy[m]) begin
               n_fail++;
               $display("FAIL rand_busy t%0d dut%0d: got %b want %b", t, m, busy_w[m], ebusy[m]);
            end
         end
      end
      in_v = '0;
      flush = 1'b0;
      $display("test_random done");
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_full();
      test_rd_zero();
      test_flush();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
